// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480 VGA timing constants and counter widths.
package vga_timing_pkg;
   localparam int H_ACTIVE     = 640;
   localparam int H_FP         = 16;
   localparam int H_SYNC       = 96;
   localparam int H_BP         = 48;
   localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int H_SYNC_START = H_ACTIVE + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
   localparam int V_ACTIVE     = 480;
   localparam int V_FP         = 10;
   localparam int V_SYNC       = 2;
   localparam int V_BP         = 33;
   localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int V_SYNC_START = V_ACTIVE + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;
   localparam int X_W          = 10;
   localparam int Y_W          = 10;
   localparam int CY_W         = 9;
endpackage

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: raster outputs of the sync generator; pix_ce input exists only with VGA_PIXEL_CE_EN.
interface vga_sync_gen_if;
   import vga_timing_pkg::*;
   logic             vga_h_sync;
   logic             vga_v_sync;
   logic             inDisplayArea;
   logic [X_W-1:0]   CounterX;
   logic [CY_W-1:0]  CounterY;
`ifdef VGA_PIXEL_CE_EN
   logic             pix_ce;
`endif
   modport master (
      output vga_h_sync, vga_v_sync, inDisplayArea, CounterX, CounterY
`ifdef VGA_PIXEL_CE_EN
      , input pix_ce
`endif
   );
   modport slave (
      input vga_h_sync, vga_v_sync, inDisplayArea, CounterX, CounterY
`ifdef VGA_PIXEL_CE_EN
      , output pix_ce
`endif
   );
endinterface

// File: rtl/vga_sync_gen_wrap_counter.sv
// wrap_counter: modulo-N counter with increment enable and terminal-count flag.
module wrap_counter #(
   parameter int N = 800,
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         tc
);
   localparam logic [W-1:0] LAST = W'(N - 1);
   assign tc = en && count == LAST;
   always_ff @(posedge clk or posedge rst)
      if (rst) count <= '0;
      else if (en) count <= tc ? '0 : count + 1'b1;
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: free-running VGA raster timing generator.
// Define VGA_PIXEL_CE_EN to add a pix_ce enable so it can run from a faster system clock.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int HA  = H_ACTIVE,
   parameter int HFP = H_FP,
   parameter int HS  = H_SYNC,
   parameter int HBP = H_BP,
   parameter int VA  = V_ACTIVE,
   parameter int VFP = V_FP,
   parameter int VS  = V_SYNC,
   parameter int VBP = V_BP
) (
   input logic            clk,
   input logic            rst,
   vga_sync_gen_if.master vga
);
   localparam int HT = HA + HFP + HS + HBP;
   localparam int VT = VA + VFP + VS + VBP;
   localparam logic [X_W-1:0] HA_X  = X_W'(HA);
   localparam logic [X_W-1:0] HSS_X = X_W'(HA + HFP);
   localparam logic [X_W-1:0] HSE_X = X_W'(HA + HFP + HS - 1);
   localparam logic [Y_W-1:0] VA_Y  = Y_W'(VA);
   localparam logic [Y_W-1:0] VSS_Y = Y_W'(VA + VFP);
   localparam logic [Y_W-1:0] VSE_Y = Y_W'(VA + VFP + VS - 1);
   logic           ce, h_tc, v_tc;
   logic [X_W-1:0] x, x_nxt;
   logic [Y_W-1:0] y, y_nxt;
   logic           h_sync, v_sync, disp;
`ifdef VGA_PIXEL_CE_EN
   assign ce = vga.pix_ce;
`else
   assign ce = 1'b1;
`endif
   wrap_counter #(.N(HT), .W(X_W)) u_h (.clk(clk), .rst(rst), .en(ce),   .count(x), .tc(h_tc));
   wrap_counter #(.N(VT), .W(Y_W)) u_v (.clk(clk), .rst(rst), .en(h_tc), .count(y), .tc(v_tc));
   // Flags are decoded from the next position so they land together with the counters.
   assign x_nxt = h_tc ? '0 : x + X_W'(ce);
   assign y_nxt = v_tc ? '0 : y + Y_W'(h_tc);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         h_sync <= 1'b1;
         v_sync <= 1'b1;
         disp   <= 1'b1;
      end else begin
         h_sync <= !(x_nxt >= HSS_X && x_nxt <= HSE_X);
         v_sync <= !(y_nxt >= VSS_Y && y_nxt <= VSE_Y);
         disp   <= x_nxt < HA_X && y_nxt < VA_Y;
      end
   assign vga.vga_h_sync    = h_sync;
   assign vga.vga_v_sync    = v_sync;
   assign vga.inDisplayArea = disp;
   assign vga.CounterX      = x;
   assign vga.CounterY      = y[CY_W-1:0];
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: scoreboard bench for default timing and a tiny-timing instance covering frame wrap.
module tb_vga_sync_gen;
   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       de;
      logic [9:0] x;
      logic [8:0] y;
   } obs_t;
`ifdef VGA_PIXEL_CE_EN
   localparam int DIV   = 4;
   localparam int MID_Y = 5;
`else
   localparam int DIV   = 1;
   localparam int MID_Y = 50;
`endif
   localparam obs_t RST_OBS = '{hs: 1'b1, vs: 1'b1, de: 1'b1, x: 10'd0, y: 9'd0};
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   vga_sync_gen_if b0();
   vga_sync_gen_if b1();
`ifdef VGA_PIXEL_CE_EN
   logic ce = 1'b0;
   assign b0.pix_ce = ce;
   assign b1.pix_ce = ce;
`endif
   vga_sync_gen d0 (.clk(clk), .rst(rst), .vga(b0));
   vga_sync_gen #(.HA(8), .HFP(2), .HS(3), .HBP(2), .VA(4), .VFP(1), .VS(2), .VBP(2))
      d1 (.clk(clk), .rst(rst), .vga(b1));
   int   checks = 0, passed = 0, fails = 0;
   int   cyc = 0;
   int   x0 = 0, y0 = 0, x1 = 0, y1 = 0;
   int   hs_low0 = 0, first_x0 = -1, hs_fall1 = 0, vs_low1 = 0, de1 = 0;
   logic prev_hs1 = 1'b1;
   obs_t q[$];
   function automatic obs_t model(int x, int y, bit s);
      int ha = s ? 8 : 640, hfp = s ? 2 : 16, hs = s ? 3 : 96;
      int va = s ? 4 : 480, vfp = s ? 1 : 10, vs = s ? 2 : 2;
      obs_t o;
      o.x  = 10'(x);
      o.y  = 9'(y);
      o.hs = !(x >= ha + hfp && x < ha + hfp + hs);
      o.vs = !(y >= va + vfp && y < va + vfp + vs);
      o.de = x < ha && y < va;
      return o;
   endfunction
   task automatic adv(inout int x, inout int y, input int ht, input int vt);
      if (x == ht - 1) begin
         x = 0;
         y = (y == vt - 1) ? 0 : y + 1;
      end else x++;
   endtask
   function automatic obs_t snap(bit s);
      return s ? {b1.vga_h_sync, b1.vga_v_sync, b1.inDisplayArea, b1.CounterX, b1.CounterY}
               : {b0.vga_h_sync, b0.vga_v_sync, b0.inDisplayArea, b0.CounterX, b0.CounterY};
   endfunction
   task automatic chk(string tag, obs_t got, obs_t exp);
      checks++;
      assert (got === exp) begin
         passed++;
      end else begin
         fails++;
         $error("FAIL %s cyc=%0d got hs=%b vs=%b de=%b x=%0d y=%0d expected hs=%b vs=%b de=%b x=%0d y=%0d",
                tag, cyc, got.hs, got.vs, got.de, got.x, got.y, exp.hs, exp.vs, exp.de, exp.x, exp.y);
      end
   endtask
   task automatic chk_int(string tag, int got, int exp);
      checks++;
      assert (got === exp) begin
         passed++;
      end else begin
         fails++;
         $error("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic tick();
      bit c = (DIV == 1) || (cyc % 4 == 3);
`ifdef VGA_PIXEL_CE_EN
      ce = c;
`endif
      if (c) begin
         adv(x0, y0, 800, 525);
         adv(x1, y1, 15, 9);
      end
      q.push_back(model(x0, y0, 1'b0));
      q.push_back(model(x1, y1, 1'b1));
      @(posedge clk);
      #1;
      cyc++;
      chk("raster_d0", snap(1'b0), q.pop_front());
      chk("raster_d1", snap(1'b1), q.pop_front());
      if (cyc <= 800 * DIV && !b0.vga_h_sync) begin
         if (first_x0 < 0) first_x0 = int'(b0.CounterX);
         hs_low0++;
      end
      if (cyc <= 135 * DIV) begin
         if (prev_hs1 && !b1.vga_h_sync) hs_fall1++;
         vs_low1 += int'(!b1.vga_v_sync);
         de1     += int'(b1.inDisplayArea);
      end
      prev_hs1 = b1.vga_h_sync;
   endtask
   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_d0", snap(1'b0), RST_OBS);
      chk("reset_d1", snap(1'b1), RST_OBS);
      rst = 1'b0;
      repeat (800 * DIV) tick();
      chk_int("line_wrap_x", int'(b0.CounterX), 0);
      chk_int("line_wrap_y", int'(b0.CounterY), 1);
      chk_int("hsync_width", hs_low0, 96 * DIV);
      chk_int("hsync_start_x", first_x0, 656);
      chk_int("small_hsync_pulses", hs_fall1, 9);
      chk_int("small_vsync_low", vs_low1, 30 * DIV);
      chk_int("small_display_clks", de1, 32 * DIV);
      while (!(x0 == 400 && y0 == MID_Y)) tick();
      #2;
      rst = 1'b1;
      #1;
      chk("async_reset_d0", snap(1'b0), RST_OBS);
      chk("async_reset_d1", snap(1'b1), RST_OBS);
      x0 = 0; y0 = 0; x1 = 0; y1 = 0;
      @(posedge clk);
      #1;
      chk("reset_hold_d0", snap(1'b0), RST_OBS);
      rst = 1'b0;
      repeat (1700 * DIV) tick();
      chk_int("restart_y", int'(b0.CounterY), 2);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Free-running 640x480 VGA raster timing generator, driven by a pixel-rate clock.
- Produces horizontal and vertical sync, a display-area flag, and the current pixel column/line.
- Sits between the clock divider and the pixel-colour logic; all video logic samples its counters.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch; H_TOTAL = sum = 800
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch; V_TOTAL = sum = 525

Ports:
- clk  in  1  pixel clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- vga_h_sync  out  1  horizontal sync, active-low
- vga_v_sync  out  1  vertical sync, active-low
- inDisplayArea  out  1  high while the current pixel is visible
- CounterX  out  10  current pixel column, 0..H_TOTAL-1
- CounterY  out  9  current line [8:0]; meaningful only while inDisplayArea

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: CounterX=0, internal line counter=0 (CounterY=0), vga_h_sync=1, vga_v_sync=1, inDisplayArea=1 (the flag is consistent with position 0,0).
- Horizontal counter: increments every clk. At H_TOTAL-1 it wraps to 0 on the next edge.
- Line counter: 10 bits internally. Increments on the same edge on which CounterX wraps. At V_TOTAL-1 it wraps to 0 when CounterX also wraps.
- CounterY carries only the low 9 bits of the line counter, so lines 512..524 alias to 0..12. This is harmless because those lines are never visible.
- All outputs are registered and computed from next-state counter values. Flags and syncs are therefore cycle-aligned with the CounterX/CounterY values presented in the same cycle: no added latency and no combinational glitches.
- vga_h_sync=0 exactly when CounterX is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [656,751] by default.
- vga_v_sync=0 exactly when the line is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. [490,491], for the full duration of those lines.
- inDisplayArea=1 exactly when CounterX<H_ACTIVE and line<V_ACTIVE.
- Period checks: one frame = H_TOTAL*V_TOTAL = 420000 clocks. One hsync pulse per line, one vsync pulse per frame.
- Reset mid-frame: all outputs return to their reset values immediately (asynchronously). Counting resumes from (0,0) on the first clk edge after rst deasserts.
- No inputs other than clk/rst; there is no handshake.

Optional Feature:
- Macro VGA_PIXEL_CE_EN.
- When defined: an extra input pix_ce (1 bit) is added. Counters and all registered outputs update only on clk edges where pix_ce=1, and hold otherwise. This allows running from the system clock with a divided enable.
- When undefined: the port is absent and the behaviour is as if pix_ce were tied to 1.

Decomposition:
- Package vga_timing_pkg holds:
  - the default timing constants, with derived H_TOTAL, V_TOTAL, H_SYNC_START/END and V_SYNC_START/END;
  - counter widths (10 for X, 10 for internal Y, 9 for the CounterY output).
- One natural sub-module, wrap_counter: a parameterized modulo-N counter with increment-enable input and terminal-count output.
  - Instantiated twice: horizontal (enable = 1 or pix_ce; terminal at 799).
  - Vertical (enable = horizontal terminal count; terminal at 524).

Test Plan:
- Assert rst for 3 clk, release -> outputs are 0/0/1/1/1 during reset; first edge gives CounterX=1, CounterY=0.
- Run 800 clk from reset -> CounterX goes 799->0 and CounterY goes 0->1 on the same edge. vga_h_sync is low for exactly 96 clk, starting when CounterX=656.
- Run a full frame (420000 clk) -> exactly 525 hsync pulses; vga_v_sync is low for exactly 1600 clk, starting at line 490 with CounterX=0; counters return to (0,0).
- Scan a full frame -> inDisplayArea is high for exactly 307200 clk; it is low at (640,0) and at (0,480), and high at (639,479).
- Assert rst at line 300, CounterX=400 -> outputs are at reset values in the same cycle, with no wait for clk; counting restarts from 0 after release.
- With VGA_PIXEL_CE_EN, drive pix_ce with a 1-in-4 pattern -> counters advance once every 4 clk; a frame takes 1680000 clk; sync widths scale by 4.
